// File: rtl/tree_loader_if.sv
// Byte-stream handshake between the host-side configuration source and tree_loader.
// master drives in_valid/in_data, slave (loader) drives in_ready.
interface tree_loader_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/tree_loader.sv
// Byte-serial writer for decision-tree node memory: parses framed node records and writes node words.
// Ports: clk, reset (async active-low), s (byte stream slave), mem_ce/we/a/d, nodes_written, tree_valid, err, err_code.
module tree_loader #(
   parameter int FEATURES        = 3,
   parameter int COEFF_BIT_DEPTH = 4,
   parameter int BIAS_BIT_DEPTH  = 10,
   parameter int MAX_CLUSTERS    = 5,
   parameter int CHANNEL_COUNT   = 1,
   parameter int TIMEOUT_CYCLES  = 255,
   localparam int SLOTS = MAX_CLUSTERS * CHANNEL_COUNT,
   localparam int AW    = ($clog2(SLOTS) < 1) ? 1 : $clog2(SLOTS),
   localparam int NW    = $clog2(SLOTS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   tree_loader_if.slave     s,
   output logic             mem_ce,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [23:0]      mem_d,
   output logic [NW-1:0]    nodes_written,
   output logic             tree_valid,
   output logic             err,
   output logic [1:0]       err_code
);

   localparam int NODE_BITS =
      2 + FEATURES + (FEATURES - 1) * COEFF_BIT_DEPTH + BIAS_BIT_DEPTH;

   localparam logic [23:0] RSV_MASK = 24'hFF_FFFF << NODE_BITS;

   localparam int TW =
      (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
   localparam logic [NW-1:0] NW_MAX = NW'(SLOTS);

   localparam logic [1:0] E_CMD  = 2'd1;
   localparam logic [1:0] E_ADDR = 2'd2;
   localparam logic [1:0] E_TO   = 2'd3;

   if (NODE_BITS > 24) begin : g_node_bits_chk
      $error("tree_loader: node word wider than 24 bits");
   end

   typedef enum logic [2:0] {
      IDLE,
      CH,
      NODE,
      W2,
      W1,
      W0,
      WRITE
   } state_t;

   state_t state, state_d;

   logic [7:0]    ch_q;
   logic [7:0]    node_q;
   logic [7:0]    w2_q;
   logic [7:0]    w1_q;
   logic [TW-1:0] cnt;

   logic          accept;
   logic          in_frame;
   logic          expire;
   logic [23:0]   word;
   logic          bad_rec;
   logic          go_write;
   logic          cmd_start;
   logic          cmd_end;
   logic          cmd_clear;
   logic          err_req;
   logic [1:0]    err_req_code;

   assign s.in_ready = reset & (state != WRITE);
   assign accept     = s.in_valid & s.in_ready;

   assign in_frame = (state == CH) | (state == NODE) | (state == W2) |
                     (state == W1) | (state == W0);

   // Expiry is decided from the registered count, so a byte landing
   // on the expiry edge is simply dropped with the frame.
   assign expire = (TIMEOUT_CYCLES != 0) & in_frame & (cnt == TO_LIM);

   assign word    = {w2_q, w1_q, s.in_data};
   assign bad_rec = (32'(ch_q) >= CHANNEL_COUNT) |
                    (32'(node_q) >= MAX_CLUSTERS) |
                    ((word & RSV_MASK) != 24'd0);

   assign cmd_start = (s.in_data == 8'hA5);
   assign cmd_end   = (s.in_data == 8'h5A);
   assign cmd_clear = (s.in_data == 8'hC3);

   assign mem_ce = (state == WRITE);
   assign mem_we = (state == WRITE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d      = state;
      go_write     = 1'b0;
      err_req      = 1'b0;
      err_req_code = 2'd0;
      if (expire) begin
         state_d      = IDLE;
         err_req      = 1'b1;
         err_req_code = E_TO;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  unique case (1'b1)
                     cmd_start: state_d = CH;
                     cmd_end,
                     cmd_clear: state_d = IDLE;
                     default: begin
                        err_req      = 1'b1;
                        err_req_code = E_CMD;
                     end
                  endcase
               end
            end
            CH:   if (accept) state_d = NODE;
            NODE: if (accept) state_d = W2;
            W2:   if (accept) state_d = W1;
            W1:   if (accept) state_d = W0;
            W0: begin
               if (accept) begin
                  if (bad_rec) begin
                     state_d      = IDLE;
                     err_req      = 1'b1;
                     err_req_code = E_ADDR;
                  end else begin
                     state_d  = WRITE;
                     go_write = 1'b1;
                  end
               end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!in_frame || accept || expire || TIMEOUT_CYCLES == 0) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch_q   <= '0;
         node_q <= '0;
         w2_q   <= '0;
         w1_q   <= '0;
      end else if (accept) begin
         if (state == CH)   ch_q   <= s.in_data;
         if (state == NODE) node_q <= s.in_data;
         if (state == W2)   w2_q   <= s.in_data;
         if (state == W1)   w1_q   <= s.in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_a <= '0;
         mem_d <= '0;
      end else if (go_write) begin
         mem_a <= AW'(ch_q) * AW'(MAX_CLUSTERS) + AW'(node_q);
         mem_d <= word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nodes_written <= '0;
         tree_valid    <= 1'b0;
         err           <= 1'b0;
         err_code      <= 2'd0;
      end else begin
         if (state == WRITE && nodes_written != NW_MAX)
            nodes_written <= nodes_written + NW'(1);
         if (state == IDLE && accept) begin
            unique case (1'b1)
               cmd_start: tree_valid <= 1'b0;
               cmd_end:   tree_valid <= ~err & (nodes_written != '0);
               cmd_clear: begin
                  nodes_written <= '0;
                  tree_valid    <= 1'b0;
                  err           <= 1'b0;
                  err_code      <= 2'd0;
               end
               default: ;
            endcase
         end
         if (err_req && !err) begin
            err      <= 1'b1;
            err_code <= err_req_code;
         end
      end
   end

endmodule

// File: tb/tb_tree_loader.sv
// Directed bench for tree_loader with a write scoreboard.
// Expected writes are queued by the stimulus and checked by a monitor.
module tb_tree_loader;

   logic        clk;
   logic        reset;
   logic        mem_ce;
   logic        mem_we;
   logic [2:0]  mem_a;
   logic [23:0] mem_d;
   logic [2:0]  nodes_written;
   logic        tree_valid;
   logic        err;
   logic [1:0]  err_code;

   tree_loader_if bus ();

   tree_loader #(
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .s             (bus.slave),
      .mem_ce        (mem_ce),
      .mem_we        (mem_we),
      .mem_a         (mem_a),
      .mem_d         (mem_d),
      .nodes_written (nodes_written),
      .tree_valid    (tree_valid),
      .err           (err),
      .err_code      (err_code)
   );

   int errors = 0;
   int checks = 0;

   logic [26:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && (mem_we || mem_ce)) begin
         logic [26:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: a=%0h d=%0h", mem_a, mem_d);
         end else begin
            e = exp_q.pop_front();
            if ({mem_a, mem_d} !== e || mem_ce !== 1'b1 || mem_we !== 1'b1) begin
               errors++;
               $display("FAIL write: got a=%0h d=%0h ce=%b we=%b want a=%0h d=%0h",
                        mem_a, mem_d, mem_ce, mem_we, e[26:24], e[23:0]);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      t = 0;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!bus.in_ready) begin
         errors++;
         $display("FAIL send_stall: ready=%b want 1", bus.in_ready);
      end else begin
         @(posedge clk);
      end
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic send_rec(input logic [7:0] ch, input logic [7:0] node,
                           input logic [23:0] w, input logic [2:0] a,
                           input bit expect_wr);
      if (expect_wr) exp_q.push_back({a, w});
      send_byte(8'hA5);
      send_byte(ch);
      send_byte(node);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ce"}, 32'(mem_ce), 0);
      chk({tag, "_we"}, 32'(mem_we), 0);
      chk({tag, "_a"}, 32'(mem_a), 0);
      chk({tag, "_d"}, 32'(mem_d), 0);
      chk({tag, "_nw"}, 32'(nodes_written), 0);
      chk({tag, "_tv"}, 32'(tree_valid), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_code"}, 32'(err_code), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time=%0t want finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk_reset_vals("rst");
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready_rel", 32'(bus.in_ready), 1);

      // Single node load
      exp_q.push_back({3'd2, 24'h401234});
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h40);
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge clk);
      chk("load_ready_lo", 32'(bus.in_ready), 0);
      chk("load_we_hi", 32'(mem_we), 1);
      @(negedge clk);
      chk("load_ready_hi", 32'(bus.in_ready), 1);
      chk("load_we_lo", 32'(mem_we), 0);
      chk("load_nw", 32'(nodes_written), 1);
      send_byte(8'h5A);
      chk("load_tv", 32'(tree_valid), 1);
      chk("load_err", 32'(err), 0);

      // Full tree and saturation
      send_byte(8'hC3);
      chk("clr_nw", 32'(nodes_written), 0);
      for (int i = 0; i < 5; i++) begin
         send_rec(8'h00, 8'(i), {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)},
                  3'(i), 1'b1);
      end
      chk("full_nw", 32'(nodes_written), 5);
      send_rec(8'h00, 8'h01, 24'h7F00FF, 3'd1, 1'b1);
      chk("sat_nw", 32'(nodes_written), 5);
      send_byte(8'h5A);
      chk("full_tv", 32'(tree_valid), 1);

      // Bad address
      send_rec(8'h00, 8'h05, 24'h000001, 3'd0, 1'b0);
      chk("badaddr_err", 32'(err), 1);
      chk("badaddr_code", 32'(err_code), 2);
      send_byte(8'h5A);
      chk("badaddr_tv", 32'(tree_valid), 0);
      send_byte(8'hC3);
      chk("clr_err", 32'(err), 0);
      chk("clr_code", 32'(err_code), 0);
      send_rec(8'h00, 8'h03, 24'h123456, 3'd3, 1'b1);
      chk("recover_nw", 32'(nodes_written), 1);
      send_byte(8'h5A);
      chk("recover_tv", 32'(tree_valid), 1);

      // Reserved bit, unknown command, first error wins
      send_rec(8'h00, 8'h01, 24'h800000, 3'd0, 1'b0);
      chk("rsv_code", 32'(err_code), 2);
      send_byte(8'hC3);
      send_byte(8'h17);
      chk("unk_err", 32'(err), 1);
      chk("unk_code", 32'(err_code), 1);
      send_rec(8'h00, 8'h01, 24'h800000, 3'd0, 1'b0);
      chk("sticky_code", 32'(err_code), 1);
      send_byte(8'hC3);
      send_rec(8'h01, 8'h00, 24'h000010, 3'd0, 1'b0);
      chk("badch_code", 32'(err_code), 2);

      // Timeout
      send_byte(8'hC3);
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (8) @(negedge clk);
      chk("to_err", 32'(err), 1);
      chk("to_code", 32'(err_code), 3);
      chk("to_ready", 32'(bus.in_ready), 1);
      send_rec(8'h00, 8'h04, 24'h0ABCDE, 3'd4, 1'b1);
      chk("to_next_nw", 32'(nodes_written), 1);

      // Reset mid-frame
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h12);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("midrst_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      chk_reset_vals("midrst");
      send_byte(8'h34);
      send_byte(8'h56);
      repeat (3) @(negedge clk);
      chk("midrst_unk_code", 32'(err_code), 1);
      chk("midrst_nw", 32'(nodes_written), 0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tree_loader.md
Name: tree_loader

Overview:
- Byte-serial configuration writer for the decision-tree node memory. It is the write side of the node words that the tree controller reads.
- Accepts framed node records over a valid/ready byte stream and validates channel, node and reserved bits.
- Writes each valid 24-bit node word to the node memory at ch*MAX_CLUSTERS + node.
- Reports session status (tree_valid, err, err_code, nodes_written) to the host-side logic.

Parameters:
FEATURES, 3, features per node; sets node-word field sizes
COEFF_BIT_DEPTH, 4, bits per stored coefficient
BIAS_BIT_DEPTH, 10, bits of node bias
MAX_CLUSTERS, 5, node slots per channel
CHANNEL_COUNT, 1, channels held in node memory
TIMEOUT_CYCLES, 255, max idle cycles between bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  in_data holds a byte
in_data  in  8  configuration byte
in_ready  out  1  loader can accept a byte
mem_ce  out  1  node memory chip enable
mem_we  out  1  node memory write enable
mem_a  out  $clog2(MAX_CLUSTERS*CHANNEL_COUNT)  node memory address
mem_d  out  24  node word to write
nodes_written  out  $clog2(MAX_CLUSTERS*CHANNEL_COUNT+1)  writes since last CLEAR; saturates at MAX_CLUSTERS*CHANNEL_COUNT
tree_valid  out  1  a complete, error-free tree has been committed
err  out  1  sticky error flag
err_code  out  2  first error: 0 none, 1 unknown command, 2 bad address or reserved bits, 3 timeout

Behaviour:
- Byte transfer: a byte is accepted on a rising edge when in_valid & in_ready. in_ready=1 in every state except WRITE; it is 0 while reset is asserted.
- Node word layout: NODE_BITS = 2+FEATURES+(FEATURES-1)*COEFF_BIT_DEPTH+BIAS_BIT_DEPTH (23 at defaults). Elaboration fails if NODE_BITS > 24.
  - Fields, MSB-first starting at bit NODE_BITS-1: child_flags[2], one_pos[FEATURES], coeffs[(FEATURES-1)*COEFF_BIT_DEPTH], bias.
  - Bits 23..NODE_BITS are reserved and must be 0.
- Commands (first byte of a frame, state IDLE):
  - 0xA5 START: a node record follows (channel byte, node byte, then word bytes [23:16], [15:8], [7:0]). Clears tree_valid.
  - 0x5A END: tree_valid <= ~err & (nodes_written != 0). Stays in IDLE.
  - 0xC3 CLEAR: nodes_written, err, err_code, tree_valid <= 0. Stays in IDLE.
  - Any other byte: err_code 1, byte dropped, stays in IDLE.
- FSM: IDLE -> CH -> NODE -> W2 -> W1 -> W0 -> WRITE -> IDLE. Each arrow out of IDLE..W0 takes exactly one accepted byte; WRITE lasts one cycle.
- Checks on leaving W0:
  - If ch >= CHANNEL_COUNT, node >= MAX_CLUSTERS, or any reserved bit is 1: no write, err_code 2, go to IDLE.
  - Otherwise go to WRITE.
- WRITE cycle:
  - mem_ce=1, mem_we=1; mem_a and mem_d are registered and stable for the whole cycle.
  - nodes_written increments (saturating).
  - Rewriting the same address counts again.
- mem_ce and mem_we are 0 in every other cycle. mem_a and mem_d hold their last value.
- Latency: last word byte accepted at edge N -> write asserted N..N+1 -> in_ready=1 again after edge N+1.
- Timeout:
  - In CH..W0, a counter increments each cycle with no accepted byte and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: frame dropped, go to IDLE, err_code 3.
  - The counter is inactive in IDLE, and entirely when TIMEOUT_CYCLES=0.
- Errors: err=1 and err_code are loaded only if err was 0 (first error wins). Both are sticky until CLEAR or reset.
- Simultaneous events: a byte accepted on the same edge the timeout expires is discarded and the timeout wins.
- Reset (asynchronous, any time including mid-frame or during WRITE):
  - State IDLE, partial frame discarded, timeout counter 0.
  - Outputs: in_ready=0 while asserted, mem_ce=0, mem_we=0, mem_a=0, mem_d=0, nodes_written=0, tree_valid=0, err=0, err_code=0.

Test Plan:
- Load node: A5 00 02 40 12 34, then 5A -> one write with mem_a=2, mem_d=0x401234, nodes_written=1, tree_valid=1, err=0; in_ready low exactly one cycle.
- Full tree: five records, nodes 0..4 on ch 0 -> writes at addresses 0..4 in order; nodes_written=5; a sixth write keeps it at 5 (saturation).
- Bad address: A5 00 05 00 00 01 -> no mem_we, err=1, err_code=2; a following 5A leaves tree_valid=0; C3 clears err; a valid record plus 5A then gives tree_valid=1.
- Reserved bit: A5 00 01 80 00 00 -> no write, err_code=2. Unknown byte 0x17 in IDLE -> err_code 1; a later error does not change err_code.
- Timeout: TIMEOUT_CYCLES=4; send A5 00, then idle 4 cycles -> IDLE, err_code 3, no write; the next A5 record is accepted normally.
- Reset mid-frame: send A5 00 01 12, pull reset low for 1 cycle, then send 34 56 -> no write; all outputs at reset values; loader in IDLE (0x34 flagged as unknown command).
